// File: rtl/sram_arb_2m.sv
// Two-master arbiter in front of a single-port block RAM.
// Round-robin or fixed priority, bounded locking, read data routed to issuer.
module sram_arb_2m #(
  parameter int AW            = 16,
  parameter int PRIORITY_MODE = 0,
  parameter int LOCK_MAX      = 16
) (
  input  logic          CLK,
  input  logic          RESETn,
  input  logic          m0_req,
  input  logic          m0_write,
  input  logic [AW-1:0] m0_addr,
  input  logic [31:0]   m0_wdata,
  input  logic [3:0]    m0_wstrb,
  input  logic          m0_lock,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [31:0]   m0_rdata,
  input  logic          m1_req,
  input  logic          m1_write,
  input  logic [AW-1:0] m1_addr,
  input  logic [31:0]   m1_wdata,
  input  logic [3:0]    m1_wstrb,
  input  logic          m1_lock,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [31:0]   m1_rdata,
  output logic [AW-1:0] sram_addr,
  output logic [31:0]   sram_wdata,
  output logic [3:0]    sram_wren,
  output logic          sram_cs,
  input  logic [31:0]   sram_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } lock_st_t;

  localparam logic [7:0] LOCK_LIM = 8'(LOCK_MAX);

  lock_st_t   lock_st;
  logic       last_gnt;
  logic [1:0] rd_owner;
  logic [7:0] lock_cnt;
  logic [7:0] lock_cnt_nxt;

  logic g0;
  logic g1;
  logic any_gnt;
  logic gnt_write;
  logic gnt_lock;

  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
    if (RESETn) begin
      unique case (1'b1)
        (lock_st == LOCK0): g0 = m0_req;
        (lock_st == LOCK1): g1 = m1_req;
        default: begin
          if (m0_req && m1_req) begin
            if (PRIORITY_MODE != 0 || last_gnt)
              g0 = 1'b1;
            else
              g1 = 1'b1;
          end else begin
            g0 = m0_req;
            g1 = m1_req;
          end
        end
      endcase
    end
  end

  assign m0_gnt  = g0;
  assign m1_gnt  = g1;
  assign any_gnt = g0 | g1;
  assign sram_cs = any_gnt;

  always_comb begin
    sram_addr  = '0;
    sram_wdata = '0;
    sram_wren  = 4'b0000;
    gnt_write  = 1'b0;
    gnt_lock   = 1'b0;
    unique case (1'b1)
      g0: begin
        sram_addr  = m0_addr;
        sram_wdata = m0_wdata;
        sram_wren  = m0_write ? m0_wstrb : 4'b0000;
        gnt_write  = m0_write;
        gnt_lock   = m0_lock;
      end
      g1: begin
        sram_addr  = m1_addr;
        sram_wdata = m1_wdata;
        sram_wren  = m1_write ? m1_wstrb : 4'b0000;
        gnt_write  = m1_write;
        gnt_lock   = m1_lock;
      end
      default: ;
    endcase
  end

  assign lock_cnt_nxt = lock_cnt + 8'd1;

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      lock_st  <= IDLE;
      last_gnt <= 1'b1;
      rd_owner <= 2'b00;
      lock_cnt <= 8'd0;
    end else begin
      rd_owner <= {any_gnt & ~gnt_write, g1};
      if (any_gnt)
        last_gnt <= g1;
      unique case (lock_st)
        IDLE: begin
          if (any_gnt && gnt_lock) begin
            lock_st  <= g0 ? LOCK0 : LOCK1;
            lock_cnt <= 8'd1;
          end
        end
        LOCK0, LOCK1: begin
          // no grant here means the owner dropped its request
          if (!any_gnt || !gnt_lock || lock_cnt_nxt == LOCK_LIM) begin
            lock_st  <= IDLE;
            lock_cnt <= 8'd0;
          end else begin
            lock_cnt <= lock_cnt_nxt;
          end
        end
        default: begin
          lock_st  <= IDLE;
          lock_cnt <= 8'd0;
        end
      endcase
    end
  end

  assign m0_rvalid = RESETn & rd_owner[1] & ~rd_owner[0];
  assign m1_rvalid = RESETn & rd_owner[1] &  rd_owner[0];
  assign m0_rdata  = m0_rvalid ? sram_rdata : 32'd0;
  assign m1_rdata  = m1_rvalid ? sram_rdata : 32'd0;

endmodule

// File: tb/tb_sram_arb_2m.sv
// Directed bench for sram_arb_2m with a behavioural block-RAM model.
// Round-robin, LOCK_MAX = 4.
module tb_sram_arb_2m;

  localparam int AW = 16;

  logic          CLK;
  logic          RESETn;
  logic          m0_req, m0_write, m0_lock, m0_gnt, m0_rvalid;
  logic [AW-1:0] m0_addr;
  logic [31:0]   m0_wdata, m0_rdata;
  logic [3:0]    m0_wstrb;
  logic          m1_req, m1_write, m1_lock, m1_gnt, m1_rvalid;
  logic [AW-1:0] m1_addr;
  logic [31:0]   m1_wdata, m1_rdata;
  logic [3:0]    m1_wstrb;
  logic [AW-1:0] sram_addr;
  logic [31:0]   sram_wdata;
  logic [3:0]    sram_wren;
  logic          sram_cs;
  logic [31:0]   sram_rdata;

  int checks = 0;
  int errors = 0;

  logic        tb_init;
  logic [31:0] mem [0:63];

  sram_arb_2m #(
    .AW(AW),
    .PRIORITY_MODE(0),
    .LOCK_MAX(4)
  ) dut (
    .CLK(CLK),
    .RESETn(RESETn),
    .m0_req(m0_req),
    .m0_write(m0_write),
    .m0_addr(m0_addr),
    .m0_wdata(m0_wdata),
    .m0_wstrb(m0_wstrb),
    .m0_lock(m0_lock),
    .m0_gnt(m0_gnt),
    .m0_rvalid(m0_rvalid),
    .m0_rdata(m0_rdata),
    .m1_req(m1_req),
    .m1_write(m1_write),
    .m1_addr(m1_addr),
    .m1_wdata(m1_wdata),
    .m1_wstrb(m1_wstrb),
    .m1_lock(m1_lock),
    .m1_gnt(m1_gnt),
    .m1_rvalid(m1_rvalid),
    .m1_rdata(m1_rdata),
    .sram_addr(sram_addr),
    .sram_wdata(sram_wdata),
    .sram_wren(sram_wren),
    .sram_cs(sram_cs),
    .sram_rdata(sram_rdata)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // RAM model: unwritten word i reads as 0xA0000000 + i
  always @(posedge CLK) begin
    if (tb_init) begin
      for (int i = 0; i < 64; i++)
        mem[i] <= 32'hA000_0000 + 32'(i);
      sram_rdata <= 32'd0;
    end else if (sram_cs) begin
      for (int b = 0; b < 4; b++)
        if (sram_wren[b])
          mem[sram_addr[5:0]][8*b +: 8] <= sram_wdata[8*b +: 8];
      if (sram_wren == 4'b0000)
        sram_rdata <= mem[sram_addr[5:0]];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic mid();
    @(negedge CLK);
  endtask

  task automatic set_m0(input logic req, input logic wr,
                        input logic [AW-1:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic lk);
    m0_req = req; m0_write = wr; m0_addr = a;
    m0_wdata = d; m0_wstrb = s; m0_lock = lk;
  endtask

  task automatic set_m1(input logic req, input logic wr,
                        input logic [AW-1:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic lk);
    m1_req = req; m1_write = wr; m1_addr = a;
    m1_wdata = d; m1_wstrb = s; m1_lock = lk;
  endtask

  initial begin
    RESETn  = 1'b0;
    tb_init = 1'b1;
    set_m0(1, 0, 16'h0001, 32'd0, 4'h0, 0);
    set_m1(1, 0, 16'h0002, 32'd0, 4'h0, 0);
    repeat (3) cyc();
    tb_init = 1'b0;

    // reset state with both masters requesting
    mid();
    chk("rst_m0_gnt", m0_gnt, 0);
    chk("rst_m1_gnt", m1_gnt, 0);
    chk("rst_cs", sram_cs, 0);
    chk("rst_addr", sram_addr, 0);
    chk("rst_m0_rvalid", m0_rvalid, 0);
    chk("rst_m1_rdata", m1_rdata, 0);
    cyc();
    set_m0(0, 0, 0, 0, 0, 0);
    set_m1(0, 0, 0, 0, 0, 0);
    RESETn = 1'b1;
    mid();
    chk("idle_cs", sram_cs, 0);
    chk("idle_wren", sram_wren, 0);
    cyc();

    // single write then read, m0 only
    set_m0(1, 1, 16'h0010, 32'hDEADBEEF, 4'hF, 0);
    mid();
    chk("t1_wr_gnt", m0_gnt, 1);
    chk("t1_wr_wren", sram_wren, 4'hF);
    chk("t1_wr_addr", sram_addr, 32'h10);
    chk("t1_wr_wdata", sram_wdata, 32'hDEADBEEF);
    cyc();
    set_m0(1, 0, 16'h0010, 32'h0, 4'hF, 0);
    mid();
    chk("t1_rd_gnt", m0_gnt, 1);
    chk("t1_rd_wren", sram_wren, 0);
    chk("t1_wr_no_rvalid", m0_rvalid, 0);
    cyc();
    set_m0(0, 0, 0, 0, 0, 0);
    mid();
    chk("t1_rvalid", m0_rvalid, 1);
    chk("t1_rdata", m0_rdata, 32'hDEADBEEF);
    chk("t1_m1_rvalid", m1_rvalid, 0);
    chk("t1_cs_idle", sram_cs, 0);
    cyc();
    mid();
    chk("t1_rvalid_gone", m0_rvalid, 0);
    cyc();

    // byte strobes: m0 full write, m1 partial write, m1 read back
    set_m0(1, 1, 16'h0005, 32'h11223344, 4'hF, 0);
    mid();
    chk("t3_m0_gnt", m0_gnt, 1);
    cyc();
    set_m0(0, 0, 0, 0, 0, 0);
    set_m1(1, 1, 16'h0005, 32'hAABBCCDD, 4'b0101, 0);
    mid();
    chk("t3_m1_wren", sram_wren, 4'b0101);
    cyc();
    set_m1(1, 0, 16'h0005, 32'h0, 4'hF, 0);
    mid();
    chk("t3_m1_rd_gnt", m1_gnt, 1);
    cyc();
    set_m1(0, 0, 0, 0, 0, 0);
    mid();
    chk("t3_m1_rvalid", m1_rvalid, 1);
    chk("t3_m1_rdata", m1_rdata, 32'h11BB33DD);
    chk("t3_m0_rvalid", m0_rvalid, 0);
    cyc();

    // round-robin contention, last grant was m1
    set_m0(1, 0, 16'h0001, 32'h0, 4'h0, 0);
    set_m1(1, 0, 16'h0002, 32'h0, 4'h0, 0);
    for (int i = 0; i < 6; i++) begin
      mid();
      chk($sformatf("t2_m0_gnt_%0d", i), m0_gnt, 32'(i % 2 == 0));
      chk($sformatf("t2_m1_gnt_%0d", i), m1_gnt, 32'(i % 2 == 1));
      chk($sformatf("t2_m0_rv_%0d", i), m0_rvalid, 32'(i % 2 == 1));
      chk($sformatf("t2_m1_rv_%0d", i), m1_rvalid,
          32'(i > 0 && i % 2 == 0));
      chk($sformatf("t2_m0_rd_%0d", i), m0_rdata,
          (i % 2 == 1) ? 32'hA0000001 : 32'h0);
      cyc();
    end
    set_m0(0, 0, 0, 0, 0, 0);
    set_m1(0, 0, 0, 0, 0, 0);
    mid();
    chk("t2_last_m1_rv", m1_rvalid, 1);
    chk("t2_last_m1_rd", m1_rdata, 32'hA0000002);
    chk("t2_last_m0_rv", m0_rvalid, 0);
    cyc();

    // forced lock release after 4 beats
    set_m0(1, 0, 16'h0003, 32'h0, 4'h0, 1);
    set_m1(1, 1, 16'h0007, 32'h12345678, 4'hF, 0);
    for (int j = 0; j < 5; j++) begin
      mid();
      chk($sformatf("t4_m0_gnt_%0d", j), m0_gnt, 32'(j < 4));
      chk($sformatf("t4_m1_gnt_%0d", j), m1_gnt, 32'(j == 4));
      chk($sformatf("t4_m0_rv_%0d", j), m0_rvalid, 32'(j >= 1));
      cyc();
      if (j == 4) set_m1(0, 0, 0, 0, 0, 0);
    end
    set_m0(0, 0, 0, 0, 0, 0);
    cyc();

    // voluntary unlock: m1 locks, second beat unlocks, m0 waits
    set_m1(1, 0, 16'h0004, 32'h0, 4'h0, 1);
    mid();
    chk("t5_m1_beat1", m1_gnt, 1);
    cyc();
    set_m1(1, 0, 16'h0004, 32'h0, 4'h0, 0);
    set_m0(1, 0, 16'h0001, 32'h0, 4'h0, 0);
    mid();
    chk("t5_m1_beat2", m1_gnt, 1);
    chk("t5_m0_stall", m0_gnt, 0);
    chk("t5_m1_rv", m1_rvalid, 1);
    chk("t5_m1_rd", m1_rdata, 32'hA0000004);
    cyc();
    set_m1(0, 0, 0, 0, 0, 0);
    mid();
    chk("t5_m0_gnt", m0_gnt, 1);
    chk("t5_m1_gnt", m1_gnt, 0);
    cyc();
    set_m0(0, 0, 0, 0, 0, 0);
    cyc();

    // lock released by dropping request: no grant that cycle
    set_m0(1, 0, 16'h0001, 32'h0, 4'h0, 1);
    mid();
    chk("t7_m0_lock_gnt", m0_gnt, 1);
    cyc();
    set_m0(0, 0, 0, 0, 0, 0);
    set_m1(1, 0, 16'h0002, 32'h0, 4'h0, 0);
    mid();
    chk("t7_release_nogo", m1_gnt, 0);
    chk("t7_release_cs", sram_cs, 0);
    cyc();
    mid();
    chk("t7_m1_after", m1_gnt, 1);
    cyc();
    set_m1(0, 0, 0, 0, 0, 0);
    cyc();

    // reset during read return
    set_m0(1, 0, 16'h0001, 32'h0, 4'h0, 0);
    mid();
    chk("t6_m0_gnt", m0_gnt, 1);
    cyc();
    RESETn = 1'b0;
    set_m1(1, 0, 16'h0002, 32'h0, 4'h0, 0);
    mid();
    chk("t6_rst_rvalid", m0_rvalid, 0);
    chk("t6_rst_rdata", m0_rdata, 0);
    chk("t6_rst_m0_gnt", m0_gnt, 0);
    chk("t6_rst_m1_gnt", m1_gnt, 0);
    chk("t6_rst_cs", sram_cs, 0);
    chk("t6_rst_addr", sram_addr, 0);
    cyc();
    RESETn = 1'b1;
    mid();
    chk("t6_post_m0_gnt", m0_gnt, 1);
    chk("t6_post_m1_gnt", m1_gnt, 0);
    chk("t6_post_rvalid", m0_rvalid, 0);
    cyc();
    mid();
    chk("t6_next_m1_gnt", m1_gnt, 1);
    chk("t6_next_m0_rv", m0_rvalid, 1);
    chk("t6_next_m0_rd", m0_rdata, 32'hA0000001);
    cyc();
    set_m0(0, 0, 0, 0, 0, 0);
    set_m1(0, 0, 0, 0, 0, 0);
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
